mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Sole owner of the byte-wide RAM port. Arbitrates between instruction-fetch
//   reads (IF) and LSB loads/stores, serialising each 1/2/4-byte access into
//   consecutive byte cycles. Returns assembled read data or store completion to the
//   requester with a one-cycle success pulse. Sits between IF/LSB and the RAM/IO bus.
// PARAMETERS
//   ADDR_W   32        address width (IF_pc, LSB_pc, mem_a)
//   DATA_W   32        max access width; bytes assembled little-endian
//   IO_BASE  32'h30000 addresses >= IO_BASE are IO; stores there obey io_buffer_full
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   asynchronous reset, active-low (rst=0 resets)
//   rdy             in   1   global ready; 0 freezes all state
//   clr             in   1   misprediction flush (synchronous)
//   io_buffer_full  in   1   IO write buffer full
//   IF_S            in   1   fetch request valid (held until IF_success)
//   IF_pc           in   32  fetch address (always 4 bytes)
//   IF_success      out  1   1-cycle pulse: IF_inst valid
//   IF_inst         out  32  fetched word
//   LSB_S           in   1   LSB request valid (held until LSB_success)
//   LSB_op          in   1   0=load, 1=store
//   LSB_pc          in   32  access address
//   LSB_len         in   2   00=1B, 01=2B, 10=4B (11 illegal, treated as 4B)
//   LSB_wdata       in   32  store data, low LSB_len bytes used
//   LSB_success     out  1   1-cycle pulse: load data valid / store done
//   LSB_rdata       out  32  load data, zero-extended (sign-ext done in LSB)
//   mem_din         in   8   RAM read byte (for address driven previous cycle)
//   mem_dout        out  8   RAM write byte
//   mem_a           out  32  RAM byte address
//   mem_wr          out  1   1=write, 0=read
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, cnt=0; all outputs 0 (mem_wr=0, mem_a=0,
//     mem_dout=0, success pulses 0, data 0).
//   - rdy=0: no state change; mem_wr registers forced 0 that cycle, pulses cleared.
//   - FSM IDLE/READ/WRITE. Grant only in IDLE. Priority LSB > IF. LSB store with
//     pc>=IO_BASE while io_buffer_full=1 is not granted; IF may be granted instead.
//   - Requester sampled at grant edge E0 and latched; request inputs ignored after.
//   - READ, N bytes: edge E0 mem_a<=addr; edge Ek (k>=1) mem_a<=addr+k (k<N).
//     Byte k captured at edge E(k+2) into bits [8k+7:8k]. At E(N+1): success<=1
//     with full data, state<=IDLE. Pulse lasts exactly 1 cycle. Word: E5.
//   - WRITE, N bytes: edge Ek (k<N): mem_a<=addr+k, mem_dout<=byte k, mem_wr<=1.
//     At EN: mem_wr<=0, LSB_success<=1, state<=IDLE. Word store done at E4.
//   - Next grant earliest at the edge after success edge (1 idle cycle min).
//   - Address increment wraps modulo 2^32; no alignment check.
//   - clr=1: any READ (IF or LSB load) aborts to IDLE, no success pulse, pending
//     pulses cleared; WRITE is never aborted (committed store) and completes with
//     LSB_success. clr in IDLE blocks grant that cycle.
//   - Simultaneous clr and final READ edge: clr wins, no pulse.
//   - Never more than one of IF_success/LSB_success high in a cycle.
// TESTING
//   1 rst=0 mid-READ -> all outputs 0 immediately, IDLE after release; IF_S retried
//     -> IF_inst=word at IF_pc, IF_success 1 cycle at E5.
//   2 IF_S+LSB_S load 4B same edge, RAM[0x100..103]=11 22 33 44 -> LSB_rdata=
//     32'h44332211 at E5, then IF served, IF_success at its E5.
//   3 LSB store 2B pc=0x200 wdata=32'hAABBCCDD -> mem_wr=1 two cycles, writes DD@0x200,
//     CC@0x201, LSB_success at E2; RAM[0x202] unchanged.
//   4 clr at E2 of IF read -> no IF_success, IDLE at E3; clr during 4B store ->
//     all 4 bytes written, LSB_success at E4.
//   5 io_buffer_full=1, LSB store pc=0x30000, IF_S=1 -> IF served, store waits;
//     full drops -> store granted, 1 byte written, success at E1.
//   6 rdy=0 for 3 cycles mid 4B load -> mem_wr=0, completion delayed exactly 3 cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and byte-RAM bus bundle between IF/LSB, the memory arbiter and RAM/IO.
// slave is the arbiter side; master is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              IF_S;
    logic [ADDR_W-1:0] IF_pc;
    logic              IF_success;
    logic [DATA_W-1:0] IF_inst;

    logic              LSB_S;
    logic              LSB_op;
    logic [ADDR_W-1:0] LSB_pc;
    logic [1:0]        LSB_len;
    logic [DATA_W-1:0] LSB_wdata;
    logic              LSB_success;
    logic [DATA_W-1:0] LSB_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  IF_S, IF_pc, LSB_S, LSB_op, LSB_pc, LSB_len, LSB_wdata, mem_din,
        output IF_success, IF_inst, LSB_success, LSB_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output IF_S, IF_pc, LSB_S, LSB_op, LSB_pc, LSB_len, LSB_wdata, mem_din,
        input  IF_success, IF_inst, LSB_success, LSB_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: serialises IF word fetches and LSB 1/2/4-byte
// loads/stores into byte cycles, LSB has priority over IF.
module mem_arbiter #(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clr,
    input  logic         io_buffer_full,
    mem_arbiter_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rbuf;
    logic              for_if;
    logic              stall_d;
    logic [7:0]        din_hold;

    logic              lsb_ok;
    logic [CNT_W-1:0]  lsb_n;
    logic [7:0]        rd_byte;
    logic [7:0]        wr_byte;
    logic [DATA_W-1:0] rbuf_next;

    // Stores to IO are held back while the IO write buffer is full.
    assign lsb_ok = bus.LSB_S &&
                    !(bus.LSB_op && (bus.LSB_pc >= IO_BASE) && io_buffer_full);

    // The RAM keeps clocking during a freeze, so the byte due at the first
    // frozen edge is parked in din_hold and consumed on the resume edge.
    assign rd_byte = stall_d ? din_hold : bus.mem_din;

    always_comb begin
        lsb_n = CNT_W'(4);
        case (bus.LSB_len)
            2'b00:   lsb_n = CNT_W'(1);
            2'b01:   lsb_n = CNT_W'(2);
            default: lsb_n = CNT_W'(4);
        endcase
    end

    // Byte lane steering: read byte cnt-2 lands in the buffer, write byte cnt goes out.
    always_comb begin
        rbuf_next = rbuf;
        wr_byte   = 8'h00;
        for (int unsigned i = 0; i < NB; i++) begin
            if (CNT_W'(cnt - CNT_W'(2)) == CNT_W'(i)) rbuf_next[8*i +: 8] = rd_byte;
            if (cnt == CNT_W'(i)) wr_byte = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            len_n           <= '0;
            addr            <= '0;
            wdata           <= '0;
            rbuf            <= '0;
            for_if          <= 1'b0;
            stall_d         <= 1'b0;
            din_hold        <= 8'h00;
            bus.IF_success  <= 1'b0;
            bus.IF_inst     <= '0;
            bus.LSB_success <= 1'b0;
            bus.LSB_rdata   <= '0;
            bus.mem_dout    <= 8'h00;
            bus.mem_a       <= '0;
            bus.mem_wr      <= 1'b0;
        end else begin
            stall_d         <= !rdy;
            bus.IF_success  <= 1'b0;
            bus.LSB_success <= 1'b0;
            if (!rdy) begin
                if (!stall_d) din_hold <= bus.mem_din;
                bus.mem_wr <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!clr && lsb_ok) begin
                            addr      <= bus.LSB_pc;
                            len_n     <= lsb_n;
                            wdata     <= bus.LSB_wdata;
                            for_if    <= 1'b0;
                            rbuf      <= '0;
                            cnt       <= CNT_W'(1);
                            bus.mem_a <= bus.LSB_pc;
                            if (bus.LSB_op) begin
                                state        <= WRITE;
                                bus.mem_dout <= bus.LSB_wdata[7:0];
                                bus.mem_wr   <= 1'b1;
                            end else begin
                                state      <= READ;
                                bus.mem_wr <= 1'b0;
                            end
                        end else if (!clr && bus.IF_S) begin
                            addr       <= bus.IF_pc;
                            len_n      <= CNT_W'(4);
                            for_if     <= 1'b1;
                            rbuf       <= '0;
                            cnt        <= CNT_W'(1);
                            bus.mem_a  <= bus.IF_pc;
                            bus.mem_wr <= 1'b0;
                            state      <= READ;
                        end
                    end
                    READ: begin
                        if (clr) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            if (cnt < len_n) bus.mem_a <= addr + ADDR_W'(cnt);
                            if (cnt >= CNT_W'(2)) rbuf <= rbuf_next;
                            if (cnt == CNT_W'(len_n + CNT_W'(1))) begin
                                state <= IDLE;
                                cnt   <= '0;
                                if (for_if) begin
                                    bus.IF_success <= 1'b1;
                                    bus.IF_inst    <= rbuf_next;
                                end else begin
                                    bus.LSB_success <= 1'b1;
                                    bus.LSB_rdata   <= rbuf_next;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    WRITE: begin
                        // Committed store: runs to completion regardless of clr.
                        if (cnt < len_n) begin
                            bus.mem_a    <= addr + ADDR_W'(cnt);
                            bus.mem_dout <= wr_byte;
                            bus.mem_wr   <= 1'b1;
                            cnt          <= cnt + CNT_W'(1);
                        end else begin
                            bus.mem_wr      <= 1'b0;
                            bus.LSB_success <= 1'b1;
                            state           <= IDLE;
                            cnt             <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model and
// hand-computed data and completion-edge expectations.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;
    logic io_buffer_full;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clr            (clr),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    int          wr_total = 0;
    int          edge_no = 0;
    int          if_pulses = 0;
    int          lsb_pulses = 0;
    int          both_hi = 0;
    int          checks = 0;
    int          failures = 0;

    // Synchronous byte RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (bus.mem_wr) begin
            ram[bus.mem_a[11:0]] <= bus.mem_dout;
            wr_total <= wr_total + 1;
        end
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    always @(posedge clk) edge_no = edge_no + 1;

    always @(posedge clk) begin
        #2;
        if (bus.IF_success) if_pulses = if_pulses + 1;
        if (bus.LSB_success) lsb_pulses = lsb_pulses + 1;
        if (bus.IF_success && bus.LSB_success) both_hi = both_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Returns the edge number of the next success pulse, -1 on timeout.
    task automatic wait_pulse(input bit sel_if, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((sel_if && bus.IF_success) || (!sel_if && bus.LSB_success)) begin
                at = edge_no;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rel(input int at, input int n);
        return (at < 0) ? 32'hFFFF_FFFF : 32'(at - n - 1);
    endfunction

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    task automatic lsb_req(input bit op, input logic [1:0] len, input logic [31:0] pc,
                           input logic [31:0] wd);
        bus.LSB_S     = 1'b1;
        bus.LSB_op    = op;
        bus.LSB_len   = len;
        bus.LSB_pc    = pc;
        bus.LSB_wdata = wd;
    endtask

    int n;
    int at;
    int w0;
    int p0;

    initial begin
        rst = 1'b0; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        bus.IF_S = 1'b0; bus.IF_pc = '0;
        bus.LSB_S = 1'b0; bus.LSB_op = 1'b0; bus.LSB_pc = '0; bus.LSB_len = '0; bus.LSB_wdata = '0;
        repeat (2) @(negedge clk);

        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        check("rst_if_success", 32'(bus.IF_success), 32'h0);
        check("rst_lsb_success", 32'(bus.LSB_success), 32'h0);
        check("rst_if_inst", bus.IF_inst, 32'h0);
        check("rst_lsb_rdata", bus.LSB_rdata, 32'h0);

        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h300, 8'hDE); preload(12'h301, 8'hAD);
        preload(12'h302, 8'hBE); preload(12'h303, 8'hEF);
        preload(12'h202, 8'h77); preload(12'hFFE, 8'hA1);
        preload(12'hFFF, 8'hA2); preload(12'h001, 8'hB4);

        // 1: reset asserted in the middle of a fetch, then the fetch is retried
        rst = 1'b1; bus.IF_S = 1'b1; bus.IF_pc = 32'h300;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1_mid_mem_a", bus.mem_a, 32'h301);
        rst = 1'b0;
        #1;
        check("t1_async_mem_a", bus.mem_a, 32'h0);
        check("t1_async_mem_wr", 32'(bus.mem_wr), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        n = edge_no;
        wait_pulse(1'b1, 20, at);
        check("t1_if_edge", rel(at, n), 32'd5);
        check("t1_if_inst", bus.IF_inst, 32'hEFBEADDE);
        bus.IF_S = 1'b0;

        // 2: simultaneous LSB load and IF fetch, LSB first
        @(negedge clk);
        lsb_req(1'b0, 2'b10, 32'h100, 32'h0);
        bus.IF_S = 1'b1; bus.IF_pc = 32'h300;
        n = edge_no;
        wait_pulse(1'b0, 20, at);
        check("t2_lsb_edge", rel(at, n), 32'd5);
        check("t2_lsb_rdata", bus.LSB_rdata, 32'h44332211);
        check("t2_if_quiet", 32'(bus.IF_success), 32'h0);
        bus.LSB_S = 1'b0;
        wait_pulse(1'b1, 20, at);
        check("t2_if_edge", rel(at, n), 32'd11);
        check("t2_if_inst", bus.IF_inst, 32'hEFBEADDE);
        bus.IF_S = 1'b0;

        // 3: 2-byte store
        @(negedge clk);
        w0 = wr_total;
        lsb_req(1'b1, 2'b01, 32'h200, 32'hAABBCCDD);
        n = edge_no;
        @(negedge clk);
        check("t3_e0_mem_wr", 32'(bus.mem_wr), 32'h1);
        check("t3_e0_mem_a", bus.mem_a, 32'h200);
        check("t3_e0_mem_dout", 32'(bus.mem_dout), 32'hDD);
        wait_pulse(1'b0, 20, at);
        check("t3_st_edge", rel(at, n), 32'd2);
        check("t3_end_mem_wr", 32'(bus.mem_wr), 32'h0);
        bus.LSB_S = 1'b0;
        @(negedge clk);
        check("t3_bytes", {8'h0, ram[12'h202], ram[12'h201], ram[12'h200]}, 32'h0077CCDD);
        check("t3_wr_cycles", 32'(wr_total - w0), 32'd2);

        // 4a: flush during a fetch aborts it silently
        @(negedge clk);
        p0 = if_pulses;
        bus.IF_S = 1'b1; bus.IF_pc = 32'h300;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1; bus.IF_S = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        repeat (8) @(negedge clk);
        check("t4_no_if_pulse", 32'(if_pulses - p0), 32'd0);
        bus.IF_S = 1'b1; bus.IF_pc = 32'h100;
        n = edge_no;
        wait_pulse(1'b1, 20, at);
        check("t4_refetch_edge", rel(at, n), 32'd5);
        check("t4_refetch_inst", bus.IF_inst, 32'h44332211);
        bus.IF_S = 1'b0;

        // 4b: flush during a 4-byte store does not abort it
        @(negedge clk);
        w0 = wr_total;
        lsb_req(1'b1, 2'b10, 32'h210, 32'h01020304);
        n = edge_no;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_pulse(1'b0, 20, at);
        check("t4_st_edge", rel(at, n), 32'd4);
        bus.LSB_S = 1'b0;
        @(negedge clk);
        check("t4_st_word", ram_word(32'h210), 32'h01020304);
        check("t4_st_wr_cycles", 32'(wr_total - w0), 32'd4);

        // 5: IO store blocked by full buffer, fetch goes first
        @(negedge clk);
        w0 = wr_total;
        p0 = lsb_pulses;
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 2'b00, 32'h30000, 32'h0000005A);
        bus.IF_S = 1'b1; bus.IF_pc = 32'h100;
        n = edge_no;
        wait_pulse(1'b1, 20, at);
        check("t5_if_edge", rel(at, n), 32'd5);
        check("t5_if_inst", bus.IF_inst, 32'h44332211);
        check("t5_store_held", 32'(lsb_pulses - p0), 32'd0);
        check("t5_no_write", 32'(wr_total - w0), 32'd0);
        bus.IF_S = 1'b0;
        io_buffer_full = 1'b0;
        n = edge_no;
        wait_pulse(1'b0, 20, at);
        check("t5_io_edge", rel(at, n), 32'd1);
        bus.LSB_S = 1'b0;
        @(negedge clk);
        check("t5_io_byte", 32'(ram[12'h000]), 32'h5A);
        check("t5_io_wr_cycles", 32'(wr_total - w0), 32'd1);

        // 1-byte load zero-extends; illegal length 11 reads 4 bytes across the wrap
        @(negedge clk);
        lsb_req(1'b0, 2'b00, 32'h103, 32'h0);
        n = edge_no;
        wait_pulse(1'b0, 20, at);
        check("b_ld1_edge", rel(at, n), 32'd2);
        check("b_ld1_data", bus.LSB_rdata, 32'h00000044);
        bus.LSB_S = 1'b0;
        @(negedge clk);
        lsb_req(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0);
        n = edge_no;
        wait_pulse(1'b0, 20, at);
        check("b_wrap_edge", rel(at, n), 32'd5);
        check("b_wrap_data", bus.LSB_rdata, 32'hB45AA2A1);
        bus.LSB_S = 1'b0;

        // 6: three-cycle freeze mid 4-byte load
        @(negedge clk);
        lsb_req(1'b0, 2'b10, 32'h100, 32'h0);
        n = edge_no;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        check("t6_ld_frozen_wr", 32'(bus.mem_wr), 32'h0);
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        wait_pulse(1'b0, 20, at);
        check("t6_ld_edge", rel(at, n), 32'd8);
        check("t6_ld_data", bus.LSB_rdata, 32'h44332211);
        bus.LSB_S = 1'b0;

        // freeze mid 4-byte store: write strobe drops, bytes still land once each
        @(negedge clk);
        w0 = wr_total;
        lsb_req(1'b1, 2'b10, 32'h220, 32'hC0FFEE11);
        n = edge_no;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_st_wr_before", 32'(bus.mem_wr), 32'h1);
        rdy = 1'b0;
        @(negedge clk);
        check("t6_st_frozen_wr", 32'(bus.mem_wr), 32'h0);
        @(negedge clk);
        rdy = 1'b1;
        wait_pulse(1'b0, 20, at);
        check("t6_st_edge", rel(at, n), 32'd6);
        bus.LSB_S = 1'b0;
        @(negedge clk);
        check("t6_st_word", ram_word(32'h220), 32'hC0FFEE11);
        check("t6_st_wr_cycles", 32'(wr_total - w0), 32'd4);

        repeat (2) @(negedge clk);
        check("one_hot_success", 32'(both_hi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
